// File: rtl/cmos_xor_sequencer.sv
// Exhaustive tester for a 2-input XOR cell: walks the four input vectors,
// lets each one settle, compares the cell output with an ideal XOR and
// reports a mismatch count and a per-vector failure map.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; results of the last pass are held
// SETTLE | vector idx driven, settle timer counting down
// SAMPLE | one cycle: compare dut_out against in_1 ^ in_2
// DONE   | one cycle: done pulse, pass flag updated, inputs back to 0
module cmos_xor_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       dut_in_1,
    output logic       dut_in_2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Timer is loaded with N-1 so that SETTLE lasts exactly N cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] ERR_MAX     = 3'd4;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       in1_q, in1_d;
    logic       in2_q, in2_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;

    logic       mismatch;
    logic [2:0] err_next;
    logic [3:0] fail_next;

    // Four-state compare so that an X or floating cell output counts as a failure.
    always_comb begin
        mismatch  = (dut_out !== (in1_q ^ in2_q));
        err_next  = err_q;
        fail_next = fail_q;
        if (mismatch) begin
            err_next  = (err_q == ERR_MAX) ? ERR_MAX : err_q + 3'd1;
            fail_next = fail_q | (4'b0001 << idx_q);
        end
    end

    // Next-state and next-output logic; abort outranks any sample in flight.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = SETTLE_LOAD;
                    in1_d   = 1'b0;
                    in2_d   = 1'b0;
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    in1_d   = 1'b0;
                    in2_d   = 1'b0;
                    pass_d  = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    in1_d   = 1'b0;
                    in2_d   = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    err_d  = err_next;
                    fail_d = fail_next;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                        in1_d   = 1'b0;
                        in2_d   = 1'b0;
                        pass_d  = (err_next == 3'd0);
                    end else begin
                        state_d        = SETTLE;
                        idx_d          = idx_q + 2'd1;
                        {in1_d, in2_d} = idx_q + 2'd1;
                        cnt_d          = SETTLE_LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign dut_in_1  = in1_q;
    assign dut_in_2  = in2_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: doc/cmos_xor_sequencer.md
CMOS_XOR_SEQUENCER -- requirements
Module: cmos_xor_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of clock cycles each input vector is held before the output is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock, all state updated on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to run one exhaustive test pass; sampled only in IDLE.
REQ-005 abort  input  1  cancel a running pass; sampled in any non-IDLE state.
REQ-006 dut_out  input  1  output of the XOR cell under test (may be 0, 1, X or Z).
REQ-007 dut_in_1  output  1  drives XOR cell in_1, registered.
REQ-008 dut_in_2  output  1  drives XOR cell in_2, registered.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse at pass completion.
REQ-011 pass  output  1  high when last completed pass had zero mismatches; held until next accepted start.
REQ-012 err_count  output  3  mismatch count of current/last pass, 0..4.
REQ-013 fail_vec  output  4  bit i set when vector i mismatched.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE, encoded in registers.
REQ-015 Vector index idx (2 bits) SHALL select {dut_in_1,dut_in_2} = idx, order 00, 01, 10, 11.
REQ-016 IDLE: start=1 -> idx=0, vector 00 driven, settle counter loaded, err_count=0, fail_vec=0, pass=0, next state SETTLE.
REQ-017 SETTLE: counter SHALL decrement each cycle; state occupies exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-018 SAMPLE (one cycle): mismatch SHALL be declared when dut_out is not exactly equal (4-state compare) to dut_in_1 XOR dut_in_2; X or Z is a mismatch.
REQ-019 On mismatch: err_count increments by 1 and fail_vec[idx] set, in the same edge that leaves SAMPLE.
REQ-020 SAMPLE with idx<3 -> idx+1, next vector driven, counter reloaded, next state SETTLE; idx==3 -> DONE.
REQ-021 DONE (one cycle): done=1, pass=1 iff final err_count==0, next state IDLE; dut_in_1/dut_in_2 return to 0.
REQ-022 Latency: done SHALL be high in the cycle following the 4*(SETTLE_CYCLES+1)-th rising edge after the edge that accepted start (12 edges at default).
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 start and DONE coincident: start ignored; new pass only from IDLE.
REQ-025 abort=1 in SETTLE or SAMPLE -> IDLE on next edge, no done pulse, dut_in_* = 0, err_count/fail_vec keep partial values, pass=0; a mismatch sampled in the same SAMPLE cycle SHALL NOT be counted.
REQ-026 abort in DONE or IDLE SHALL have no effect.
REQ-027 err_count SHALL saturate at 4 and never wrap.

Reset
REQ-028 rst=0 SHALL immediately (without clock) force state IDLE, idx=0, counter=0, dut_in_1=0, dut_in_2=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-029 Reset asserted mid-pass SHALL discard the pass; no done pulse on deassertion.
REQ-030 First start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 Ideal XOR model, start pulse -> vectors 00,01,10,11 each held 3 cycles; done 12 edges later; pass=1, err_count=0, fail_vec=0000.
REQ-032 dut_out stuck at 0 -> err_count=2, fail_vec=0110, pass=0, done pulses once.
REQ-033 dut_out undriven (Z) -> err_count=4, fail_vec=1111, pass=0.
REQ-034 start re-pulsed at edge 5 of a pass -> ignored; done still at edge 12, exactly one done pulse.
REQ-035 abort in SETTLE of vector 2 with stuck-at-0 model -> IDLE next edge, no done, err_count=1, fail_vec=0010, dut_in_*=0.
REQ-036 rst low mid-SETTLE of vector 1 -> all outputs 0 asynchronously; new start after release runs full pass to done with correct results.
